pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the single-cycle half adder; adds or subtracts two WIDTH-bit unsigned operands.
- Carry-split pipeline of STAGES registers with valid/ready flow control and per-stage bubble collapse.
- Optional floor-at-zero saturation on subtract and a sideband tag carried alongside each result.
- Sits between an operand source and a consumer that may apply backpressure.

Parameters:
- WIDTH, 9, operand width in bits (>=1).
- STAGES, 2, pipeline depth = latency in cycles (1..WIDTH); chunk width CW = ceil(WIDTH/STAGES), last chunk takes the remainder.
- SATURATE, 0, 1 = clamp negative subtract results to 0.
- TAG_W, 4, sideband tag width (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- op_sub  in  1  0 = data_in0+data_in1, 1 = data_in0-data_in1.
- data_in0  in  WIDTH  operand A, unsigned.
- data_in1  in  WIDTH  operand B, unsigned.
- tag_in  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- data_out  out  WIDTH+1  result: add = zero-extended sum; sub = two's-complement difference.
- tag_out  out  TAG_W  tag of the current result.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits cleared, all data/tag registers zeroed. In the cycle after reset, out_valid=0, data_out=0, tag_out=0, in_ready=1.
- Reset mid-operation: in-flight beats are discarded and never emitted.
- Transfer rules:
  - Input beat accepted when in_valid && in_ready.
  - Output beat consumed when out_valid && out_ready.
- Stage i (0..STAGES-1) holds valid[i]; stage STAGES-1 drives the outputs.
  - rdy[STAGES-1] = !valid[STAGES-1] || out_ready.
  - rdy[i] = !valid[i] || rdy[i+1].
  - in_ready = rdy[0].
  - Combinational path from out_ready to in_ready is permitted.
- A stage with rdy[i]=1 loads from its predecessor (input port for stage 0), including loading an empty beat. Bubbles therefore collapse, and capacity = STAGES beats.
- Arithmetic: subtract uses A + ~B + 1 over WIDTH+1 bits, with B zero-extended before inversion.
  - Stage k adds chunk k plus the carry registered by stage k-1.
  - Lower chunks, upper operand chunks, op_sub and tag travel in stage registers.
- Latency: exactly STAGES cycles from acceptance to out_valid when no stall occurs.
- Throughput: 1 beat/cycle with out_ready held 1.
- Sub result range is -(2^WIDTH-1)..(2^WIDTH-1), so there is no overflow. Add max = 2^(WIDTH+1)-2.
- SATURATE=1 and a negative sub result: data_out=0. Add is unaffected.
- data_out and tag_out are 0 whenever out_valid=0.
- While out_valid && !out_ready, data_out and tag_out are held stable.
- Order is strictly preserved. No beat is dropped or duplicated.
- Simultaneous accept and consume with the pipe full: allowed, capacity is unchanged.

Decomposition:
- Package pipelined_adder_pkg holds:
  - op_e enum (OP_ADD=0, OP_SUB=1).
  - Function chunk_lo(k, WIDTH, STAGES) returning a chunk's bit offset.
  - Function chunk_w(k, WIDTH, STAGES) returning a chunk's width.
- Sub-module adder_pipe_stage, instantiated STAGES times via generate, holds one stage's valid/data/carry/tag registers and its chunk add.

Test Plan:
All scenarios use WIDTH=9, STAGES=3 (CW=3) and TAG_W=4 unless noted.
1. Hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, data_out=0 throughout; in_ready=1 on the first cycle after release.
2. Add 0x1FF+0x1FF, tag 5, out_ready=1 -> exactly 3 cycles later out_valid=1, data_out=10'h3FE, tag_out=5. Same for 7+1 -> 8, carry crossing the chunk boundary.
3. Subtract 5-9:
   - SATURATE=0 -> data_out=10'h3FC (-4).
   - SATURATE=1 -> data_out=0.
   - 9-5 -> 4 in both modes.
4. out_ready=0, offer 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) -> 3 accepted, in_ready=0. Raise out_ready -> 2, 4, 6, 8 emitted in order, one per cycle, with data stable while stalled.
5. Accept 2 beats, assert rst for 1 cycle at cycle 1 -> no out_valid afterwards, all outputs 0.
6. Random in_valid/out_ready (50%) over 2000 beats against a scoreboard -> every result matches a reference model, in order, with no loss and no duplication.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared types and chunk-geometry helpers for the carry-split pipelined adder.
// Latency: none. These are compile-time helpers only.
// Backpressure: not applicable. No flow control lives here.
package pipelined_adder_pkg;

  // Operation select carried with each beat.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Nominal chunk width: ceil(width / stages).
  function automatic int chunk_cw(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Bit offset of chunk k. It is clamped to width so that trailing chunks
  // start at the top when ceil() leaves them with nothing to add.
  function automatic int chunk_lo(input int k, input int width, input int stages);
    int lo;
    lo = k * chunk_cw(width, stages);
    if (lo > width) lo = width;
    return lo;
  endfunction

  // Width of chunk k. The last chunk takes whatever remains, which can be
  // zero bits wide for some width/stages combinations.
  function automatic int chunk_w(input int k, input int width, input int stages);
    int lo;
    int hi;
    lo = chunk_lo(k, width, stages);
    if (k >= stages - 1) hi = width;
    else                 hi = chunk_lo(k + 1, width, stages);
    return hi - lo;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One adder pipeline stage: adds its operand chunk plus the incoming carry and registers the beat.
// Latency: 1 cycle. The last stage also forms the sign bit and applies optional floor-at-zero.
// Backpressure: holds its beat while valid and downstream is not ready. It loads (even a bubble) otherwise.
module adder_pipe_stage
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int TAG_W    = 4,
  parameter int LO       = 0,
  parameter int W        = 3,
  parameter bit LAST     = 1'b0,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic             nxt_rdy_i,
  output logic             rdy_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH:0]   b_i,
  input  logic [WIDTH:0]   sum_i,
  input  logic             cin_i,
  input  logic             op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH:0]   b_o,
  output logic [WIDTH:0]   sum_o,
  output logic             cout_o,
  output logic             op_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             vld_q;
  logic [WIDTH-1:0] a_q,   a_d;
  logic [WIDTH:0]   b_q,   b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             op_q,  op_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [WIDTH:0]   part_sum;
  logic             part_cout;

  // A stage accepts a new beat (or bubble) whenever it is empty or its own beat moves on.
  assign rdy_o = !vld_q || nxt_rdy_i;

  if (W > 0) begin : g_add
    logic [W:0] chunk;
    // Chunk add: this stage's slice of A and (possibly inverted) B plus the carry from the stage below.
    always_comb begin
      chunk     = {1'b0, a_i[LO +: W]} + {1'b0, b_i[LO +: W]} + {{W{1'b0}}, cin_i};
      part_sum  = sum_i;
      part_sum[LO +: W] = chunk[W-1:0];
      part_cout = chunk[W];
    end
  end else begin : g_pass
    // Zero-width trailing chunk: nothing to add, carry passes straight through.
    assign part_sum  = sum_i;
    assign part_cout = cin_i;
  end

  // Next-state beat: finish the result in the last stage and zero everything for a bubble.
  always_comb begin
    a_d    = a_i;
    b_d    = b_i;
    sum_d  = part_sum;
    cout_d = part_cout;
    op_d   = op_i;
    tag_d  = tag_i;
    if (LAST) begin
      // Top bit of the WIDTH+1 result: A is zero-extended, B's extension bit is 1 only for subtract.
      sum_d[WIDTH] = b_i[WIDTH] ^ part_cout;
      // For subtract the top bit is the sign. The range never overflows, so negative means A < B.
      if (SATURATE && (op_i == OP_SUB) && sum_d[WIDTH]) sum_d = '0;
    end
    if (!vld_i) begin
      a_d    = '0;
      b_d    = '0;
      sum_d  = '0;
      cout_d = 1'b0;
      op_d   = 1'b0;
      tag_d  = '0;
    end
  end

  // Stage register: cleared on reset, loaded whenever this stage is ready, held while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      op_q   <= 1'b0;
      tag_q  <= '0;
    end else if (rdy_o) begin
      vld_q  <= vld_i;
      a_q    <= a_d;
      b_q    <= b_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      op_q   <= op_d;
      tag_q  <= tag_d;
    end
  end

  assign vld_o  = vld_q;
  assign a_o    = a_q;
  assign b_o    = b_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign op_o   = op_q;
  assign tag_o  = tag_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit unsigned add/subtract, carry split over STAGES chunk stages, with a sideband tag.
// Latency: STAGES cycles from acceptance to out_valid when there are no stalls. Throughput is 1 beat/cycle.
// Backpressure: valid/ready with per-stage bubble collapse. in_ready depends combinationally on out_ready.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int STAGES   = 2,
  parameter bit SATURATE = 1'b0,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   data_out,
  output logic [TAG_W-1:0] tag_out
);

  // Index g is the input side of stage g. Index STAGES is the output of the last stage.
  logic             vld_c  [0:STAGES];
  logic             rdy_c  [0:STAGES];
  logic [WIDTH-1:0] a_c    [0:STAGES];
  logic [WIDTH:0]   b_c    [0:STAGES];
  logic [WIDTH:0]   sum_c  [0:STAGES];
  logic             cout_c [0:STAGES];
  logic             op_c   [0:STAGES];
  logic [TAG_W-1:0] tag_c  [0:STAGES];

  op_e op_in;
  assign op_in = op_e'(op_sub);

  // Pipe entry. Subtract is A + ~B + 1, so B is zero-extended and inverted here, and the +1 enters as the first carry.
  assign vld_c[0]  = in_valid;
  assign a_c[0]    = data_in0;
  assign b_c[0]    = (op_in == OP_SUB) ? ~{1'b0, data_in1} : {1'b0, data_in1};
  assign sum_c[0]  = '0;
  assign cout_c[0] = (op_in == OP_SUB);
  assign op_c[0]   = op_sub;
  assign tag_c[0]  = tag_in;

  // The ready chain runs from the consumer back to the producer.
  assign rdy_c[STAGES] = out_ready;
  assign in_ready      = rdy_c[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH    (WIDTH),
      .TAG_W    (TAG_W),
      .LO       (chunk_lo(g, WIDTH, STAGES)),
      .W        (chunk_w(g, WIDTH, STAGES)),
      .LAST     (g == STAGES - 1),
      .SATURATE (SATURATE)
    ) u_stage (
      .clk_i     (clk),
      .rst_i     (rst),
      .vld_i     (vld_c[g]),
      .nxt_rdy_i (rdy_c[g+1]),
      .rdy_o     (rdy_c[g]),
      .a_i       (a_c[g]),
      .b_i       (b_c[g]),
      .sum_i     (sum_c[g]),
      .cin_i     (cout_c[g]),
      .op_i      (op_c[g]),
      .tag_i     (tag_c[g]),
      .vld_o     (vld_c[g+1]),
      .a_o       (a_c[g+1]),
      .b_o       (b_c[g+1]),
      .sum_o     (sum_c[g+1]),
      .cout_o    (cout_c[g+1]),
      .op_o      (op_c[g+1]),
      .tag_o     (tag_c[g+1])
    );
  end

  // Bubbles are loaded as all-zero, so the last stage's registers already read 0 whenever out_valid is 0.
  assign out_valid = vld_c[STAGES];
  assign data_out  = sum_c[STAGES];
  assign tag_out   = tag_c[STAGES];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: plain and saturating instances share one stimulus stream.
// Latency: directed beats measure cycles from acceptance to out_valid.
// Backpressure: stall, full-pipe and random valid/ready patterns are exercised.
module tb_pipelined_adder;

  localparam int W = 9;
  localparam int S = 3;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         op_sub;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [T-1:0] tag_in;
  logic         out_ready;

  logic         in_ready,  in_ready_s;
  logic         out_valid, out_valid_s;
  logic [W:0]   data_out,  data_out_s;
  logic [T-1:0] tag_out,   tag_out_s;

  pipelined_adder #(.WIDTH(W), .STAGES(S), .SATURATE(1'b0), .TAG_W(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .data_in0(d0), .data_in1(d1), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .tag_out(tag_out));

  pipelined_adder #(.WIDTH(W), .STAGES(S), .SATURATE(1'b1), .TAG_W(T)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .op_sub(op_sub),
    .data_in0(d0), .data_in1(d1), .tag_in(tag_in), .out_valid(out_valid_s),
    .out_ready(out_ready), .data_out(data_out_s), .tag_out(tag_out_s));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W:0]   r0;
    logic [W:0]   r1;
    logic [T-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact arithmetic on wide integers, then truncated to WIDTH+1 bits.
  function automatic logic [W:0] ref_res(input logic sub, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic sat);
    int r;
    if (!sub) r = int'(a) + int'(b);
    else begin
      r = int'(a) - int'(b);
      if (sat && r < 0) r = 0;
    end
    return r[W:0];
  endfunction

  // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
  logic         stall_prev = 1'b0;
  logic [W:0]   prev_d0, prev_d1;
  logic [T-1:0] prev_tag;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rst) begin
        sb_q.delete();
        stall_prev = 1'b0;
      end else begin
        check_eq("in_ready_pair", in_ready_s, in_ready);
        check_eq("out_valid_pair", out_valid_s, out_valid);
        if (stall_prev) begin
          check_eq("stall_hold_data", data_out, prev_d0);
          check_eq("stall_hold_data_sat", data_out_s, prev_d1);
          check_eq("stall_hold_tag", tag_out, prev_tag);
        end
        if (!out_valid) begin
          check_eq("idle_data", data_out, 0);
          check_eq("idle_data_sat", data_out_s, 0);
          check_eq("idle_tag", tag_out, 0);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) check_eq("unexpected_out", sb_q.size(), 1);
          else begin
            e = sb_q.pop_front();
            check_eq("sb_data", data_out, e.r0);
            check_eq("sb_data_sat", data_out_s, e.r1);
            check_eq("sb_tag", tag_out, e.tag);
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_d0    = data_out;
        prev_d1    = data_out_s;
        prev_tag   = tag_out;
        if (in_valid && in_ready)
          sb_q.push_back('{r0: ref_res(op_sub, d0, d1, 1'b0),
                           r1: ref_res(op_sub, d0, d1, 1'b1), tag: tag_in});
      end
    end
  end

  task automatic send_and_expect(input string nm, input logic sub, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [T-1:0] t,
                                 input logic [W:0] e0, input logic [W:0] e1);
    int lat;
    bit got;
    out_ready = 1'b1;
    op_sub = sub; d0 = a; d1 = b; tag_in = t; in_valid = 1'b1;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check_eq({nm, "_accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    check_eq({nm, "_latency"}, lat, S);
    check_eq({nm, "_data"}, data_out, e0);
    check_eq({nm, "_data_sat"}, data_out_s, e1);
    check_eq({nm, "_tag"}, tag_out, t);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int idx;
    int guard;
    // Reset held for two cycles while a beat is offered.
    rst = 1'b1; in_valid = 1'b1; op_sub = 1'b0; d0 = 9'h1AB; d1 = 9'h055; tag_in = 4'hA;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_data", data_out, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_out_valid", out_valid, 0);
    check_eq("post_rst_data", data_out, 0);
    check_eq("post_rst_tag", tag_out, 0);
    @(posedge clk); #1;

    // Add at the maximum and across a chunk boundary. Subtract in both signs.
    send_and_expect("add_max",   1'b0, 9'h1FF, 9'h1FF, 4'd5, 10'h3FE, 10'h3FE);
    send_and_expect("add_carry", 1'b0, 9'd7,   9'd1,   4'd9, 10'd8,   10'd8);
    send_and_expect("sub_neg",   1'b1, 9'd5,   9'd9,   4'd3, 10'h3FC, 10'd0);
    send_and_expect("sub_pos",   1'b1, 9'd9,   9'd5,   4'd6, 10'd4,   10'd4);

    // Full pipe under backpressure: four beats offered, only STAGES accepted.
    out_ready = 1'b0; op_sub = 1'b0;
    idx = 0; acc = 0;
    d0 = 9'd1; d1 = 9'd1; tag_in = 4'd1; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      if (acc > idx && idx < 3) begin
        idx++;
        d0 = 9'(idx + 1); d1 = 9'(idx + 1); tag_in = 4'(idx + 1);
      end
    end
    @(negedge clk);
    check_eq("full_accepted", acc, 3);
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_out_valid", out_valid, 1);
    check_eq("full_head_data", data_out, 10'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("drain_valid", out_valid, 1);
      check_eq("drain_data", data_out, 10'(2 * (k + 1)));
      if (k == 0) check_eq("drain_in_ready", in_ready, 1);
      @(posedge clk); #1;
      if (k == 0) in_valid = 1'b0;
    end

    // Reset with two beats in flight: nothing may come out afterwards.
    out_ready = 1'b1; op_sub = 1'b0;
    d0 = 9'd10; d1 = 9'd20; tag_in = 4'd1; in_valid = 1'b1;
    @(negedge clk);
    check_eq("midrst_accept0", in_ready, 1);
    @(posedge clk); #1;
    d0 = 9'd30; d1 = 9'd40; tag_in = 4'd2;
    @(negedge clk);
    check_eq("midrst_accept1", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_data", data_out, 0);
      check_eq("midrst_tag", tag_out, 0);
    end
    @(posedge clk); #1;

    // Random valid/ready traffic against the scoreboard.
    acc = 0; guard = 0;
    while (acc < 2000 && guard < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      op_sub    = 1'($urandom_range(0, 1));
      d0        = 9'($urandom_range(0, 511));
      d1        = 9'($urandom_range(0, 511));
      tag_in    = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      guard++;
    end
    check_eq("rand_beats", acc, 2000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 5) @(posedge clk);
    #1;
    check_eq("drain_empty", sb_q.size(), 0);
    check_eq("drain_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
